// File: rtl/registradores_param.sv
// Parameterised register file with per-register busy bits and a sequential
// clear engine. Optional macro REGFILE_BYPASS_EN forwards same-cycle writes to the read ports.
module registradores_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issueReg,
    output logic              busy1,
    output logic              busy2,
    input  logic              clear,
    output logic              clearBusy
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
    localparam bit                HARD_ZERO = (ZERO_REG == 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;

    logic              w_idle;
    logic              w_wr_acc;
    logic              w_issue_acc;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic              w_bz1;
    logic              w_bz2;

    assign w_idle      = (r_state == S_IDLE);
    assign w_wr_acc    = regWrite && w_idle && !(HARD_ZERO && (writeReg == '0));
    assign w_issue_acc = issue    && w_idle && !(HARD_ZERO && (issueReg == '0));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (clear) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            S_CLEAR: begin
                // The counter wraps to zero on the final step, ready for the next clear.
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == LAST_IDX) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // NOTE: the storage array is reset explicitly because reset must leave
    // every register reading zero; this keeps it out of plain RAM macros.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_state == S_CLEAR) begin
            r_regs[r_cnt] <= '0;
        end else if (w_wr_acc) begin
            r_regs[writeReg] <= writeData;
        end
    end

    // Issue is assigned after the write clear so a same-edge set wins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_busy <= '0;
        end else if (r_state == S_CLEAR) begin
            r_busy[r_cnt] <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_busy[writeReg] <= 1'b0;
            end
            if (w_issue_acc) begin
                r_busy[issueReg] <= 1'b1;
            end
        end
    end

    always_comb begin
        w_rd1 = r_regs[readReg1];
        w_rd2 = r_regs[readReg2];
        w_bz1 = r_busy[readReg1];
        w_bz2 = r_busy[readReg2];
        if (HARD_ZERO && (readReg1 == '0)) begin
            w_rd1 = '0;
            w_bz1 = 1'b0;
        end
        if (HARD_ZERO && (readReg2 == '0)) begin
            w_rd2 = '0;
            w_bz2 = 1'b0;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic w_hit1;
    logic w_hit2;

    // w_wr_acc already excludes the hardwired register, so it never forwards.
    assign w_hit1    = w_wr_acc && (writeReg == readReg1);
    assign w_hit2    = w_wr_acc && (writeReg == readReg2);
    assign readData1 = w_hit1 ? writeData : w_rd1;
    assign readData2 = w_hit2 ? writeData : w_rd2;
    assign busy1     = w_hit1 ? 1'b0 : w_bz1;
    assign busy2     = w_hit2 ? 1'b0 : w_bz2;
`else
    assign readData1 = w_rd1;
    assign readData2 = w_rd2;
    assign busy1     = w_bz1;
    assign busy2     = w_bz2;
`endif

    assign clearBusy = (r_state == S_CLEAR);

endmodule

// File: tb/tb_registradores_param.sv
// Self-checking bench for registradores_param: directed scenarios followed by
// random traffic compared against a behavioural register-file model.
module tb_registradores_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        regWrite;
    logic [2:0]  writeReg;
    logic [15:0] writeData;
    logic [2:0]  readReg1;
    logic [2:0]  readReg2;
    logic [15:0] readData1;
    logic [15:0] readData2;
    logic        issue;
    logic [2:0]  issueReg;
    logic        busy1;
    logic        busy2;
    logic        clear;
    logic        clearBusy;

    int checks   = 0;
    int failures = 0;

    // Reference model: contents, busy flags and remaining clear steps.
    logic [15:0] m_reg  [8];
    bit          m_busy [8];
    int          m_clear_left = 0;
    int          m_clear_idx  = 0;

    registradores_param #(
        .DATA_W  (16),
        .ADDR_W  (3),
        .ZERO_REG(1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .regWrite (regWrite),
        .writeReg (writeReg),
        .writeData(writeData),
        .readReg1 (readReg1),
        .readReg2 (readReg2),
        .readData1(readData1),
        .readData2(readData2),
        .issue    (issue),
        .issueReg (issueReg),
        .busy1    (busy1),
        .busy2    (busy2),
        .clear    (clear),
        .clearBusy(clearBusy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_wr_acc();
        return regWrite && (m_clear_left == 0) && (writeReg != 3'd0);
    endfunction

    function automatic logic [15:0] exp_rd(input logic [2:0] a);
        if (a == 3'd0) return 16'h0000;
`ifdef REGFILE_BYPASS_EN
        if (model_wr_acc() && writeReg == a) return writeData;
`endif
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic [2:0] a);
        if (a == 3'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (model_wr_acc() && writeReg == a) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    task automatic model_update();
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                m_reg[i]  = 16'h0000;
                m_busy[i] = 1'b0;
            end
            m_clear_left = 0;
            m_clear_idx  = 0;
        end else if (m_clear_left > 0) begin
            m_reg[m_clear_idx]  = 16'h0000;
            m_busy[m_clear_idx] = 1'b0;
            m_clear_idx++;
            m_clear_left--;
        end else begin
            if (model_wr_acc()) begin
                m_reg[writeReg]  = writeData;
                m_busy[writeReg] = 1'b0;
            end
            if (issue && issueReg != 3'd0) m_busy[issueReg] = 1'b1;
            if (clear) begin
                m_clear_left = 8;
                m_clear_idx  = 0;
            end
        end
    endtask

    // Compare all outputs with the model, then advance one clock edge.
    task automatic tick();
        #1;
        chk("rd1",   readData1, exp_rd(readReg1));
        chk("rd2",   readData2, exp_rd(readReg2));
        chk("busy1", busy1,     exp_busy(readReg1));
        chk("busy2", busy2,     exp_busy(readReg2));
        chk("clrb",  clearBusy, m_clear_left > 0);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        regWrite  = 1'b1;
        writeReg  = a;
        writeData = d;
    endtask

    task automatic idle_inputs();
        reset    = 1'b1;
        regWrite = 1'b0;
        issue    = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic fill_regs(input logic [15:0] base);
        for (int a = 1; a < 8; a++) begin
            wr(3'(a), base + 16'(a * 16'h0111));
            tick();
        end
        regWrite = 1'b0;
    endtask

    initial begin
        reset = 1'b0; regWrite = 1'b0; writeReg = '0; writeData = '0;
        readReg1 = '0; readReg2 = '0; issue = 1'b0; issueReg = '0; clear = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_reg[i] = 16'h0000; m_busy[i] = 1'b0;
        end
        @(negedge clk);
        @(posedge clk);
        model_update();
        @(negedge clk);
        idle_inputs();

        // Reset state on every address.
        for (int a = 0; a < 8; a++) begin
            readReg1 = 3'(a);
            readReg2 = 3'(7 - a);
            #1;
            chk("rst_rd1", readData1, 16'h0000);
            chk("rst_rd2", readData2, 16'h0000);
            chk("rst_busy", {busy1, busy2}, 2'b00);
            chk("rst_clrb", clearBusy, 1'b0);
            tick();
        end

        // Ordinary write, then write to hardwired zero.
        wr(3'd3, 16'hBEEF); readReg1 = 3'd3; tick();
        regWrite = 1'b0; #1; chk("beef", readData1, 16'hBEEF); tick();
        wr(3'd0, 16'h1234); tick();
        regWrite = 1'b0; readReg1 = 3'd0; #1; chk("r0_zero", readData1, 16'h0000); tick();

        // Busy set, clear by write, and set-wins on the same edge.
        issue = 1'b1; issueReg = 3'd5; tick();
        issue = 1'b0; readReg1 = 3'd5; #1; chk("busy_set", busy1, 1'b1);
        wr(3'd5, 16'h00AA); tick();
        regWrite = 1'b0; #1; chk("busy_clr", busy1, 1'b0); tick();
        issue = 1'b1; issueReg = 3'd5; wr(3'd5, 16'h00AA); tick();
        issue = 1'b0; regWrite = 1'b0; #1;
        chk("set_wins", busy1, 1'b1);
        chk("set_wins_data", readData1, 16'h00AA);
        tick();
        issue = 1'b1; issueReg = 3'd0; tick();
        issue = 1'b0; readReg2 = 3'd0; #1; chk("r0_never_busy", busy2, 1'b0); tick();

        // Full clear sequence with writes and issues attempted throughout.
        fill_regs(16'h1000);
        clear = 1'b1; tick();
        clear = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr(3'(i), 16'hFFFF); issue = 1'b1; issueReg = 3'(7 - i); clear = 1'b1;
            readReg1 = 3'(i); readReg2 = 3'(7 - i);
            #1; chk("clr_active", clearBusy, 1'b1);
            tick();
        end
        idle_inputs();
        #1; chk("clr_done", clearBusy, 1'b0);
        for (int a = 0; a < 8; a++) begin
            readReg1 = 3'(a);
            #1; chk("clr_zero", readData1, 16'h0000); chk("clr_nobusy", busy1, 1'b0);
            tick();
        end

        // Reset aborting a clear on its third cycle.
        fill_regs(16'h2000);
        issue = 1'b1; issueReg = 3'd7; tick(); issue = 1'b0;
        clear = 1'b1; tick(); clear = 1'b0;
        tick(); tick();
        reset = 1'b0; #1; chk("abort_pre", clearBusy, 1'b1); tick();
        reset = 1'b1; #1; chk("abort_idle", clearBusy, 1'b0);
        for (int a = 0; a < 8; a++) begin
            readReg1 = 3'(a); readReg2 = 3'(a);
            #1; chk("abort_zero", readData1, 16'h0000); chk("abort_nobusy", busy2, 1'b0);
            tick();
        end

        // Same-cycle read of a register being written.
        wr(3'd2, 16'h1111); tick();
        wr(3'd2, 16'h5A5A); readReg1 = 3'd2; #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_rd", readData1, 16'h5A5A);
`else
        chk("nobypass_rd", readData1, 16'h1111);
`endif
        tick();
        regWrite = 1'b0; #1; chk("after_wr", readData1, 16'h5A5A); tick();

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            reset     = ($urandom_range(0, 79) != 0);
            regWrite  = $urandom_range(0, 1) == 1;
            writeReg  = 3'($urandom_range(0, 7));
            writeData = 16'($urandom);
            issue     = $urandom_range(0, 2) == 0;
            issueReg  = 3'($urandom_range(0, 7));
            clear     = ($urandom_range(0, 39) == 0);
            readReg1  = ($urandom_range(0, 3) == 0) ? writeReg : 3'($urandom_range(0, 7));
            readReg2  = 3'($urandom_range(0, 7));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/registradores_param.md
REGISTRADORES_PARAM -- requirements
Module: registradores_param

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when 1.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port regWrite  input  1  write enable.
REQ-007 SHALL have port writeReg  input  ADDR_W  write address.
REQ-008 SHALL have port writeData  input  DATA_W  write data.
REQ-009 SHALL have ports readReg1, readReg2  input  ADDR_W  read addresses.
REQ-010 SHALL have ports readData1, readData2  output  DATA_W  read data.
REQ-011 SHALL have port issue  input  1  marks issueReg as pending-write (busy).
REQ-012 SHALL have port issueReg  input  ADDR_W  register to mark busy.
REQ-013 SHALL have ports busy1, busy2  output  1  busy bit of readReg1 / readReg2.
REQ-014 SHALL have port clear  input  1  starts a sequential clear of all registers.
REQ-015 SHALL have port clearBusy  output  1  high while the clear sequence runs.

Function
REQ-016 Reads SHALL be combinational: readDataN = stored value of readRegN; 0 when ZERO_REG=1 and readRegN=0.
REQ-017 Write SHALL occur at the rising edge when regWrite=1, FSM in IDLE, and not (ZERO_REG=1 and writeReg=0).
REQ-018 Each register SHALL have one busy bit; issue=1 in IDLE sets busy[issueReg] at the edge; an accepted write clears busy[writeReg].
REQ-019 Simultaneous issue and accepted write to the same register: set SHALL win (busy=1, data written).
REQ-020 With ZERO_REG=1, register 0 SHALL never become busy; busy1/busy2 SHALL be 0 for address 0.
REQ-021 busyN SHALL combinationally equal busy[readRegN].
REQ-022 FSM states SHALL be IDLE and CLEAR; IDLE->CLEAR when clear=1; internal counter starts at 0.
REQ-023 In CLEAR, each cycle SHALL zero register[counter] and busy[counter], then increment; after counter=DEPTH-1, return to IDLE; CLEAR lasts exactly DEPTH cycles.
REQ-024 clearBusy SHALL be 1 exactly while in CLEAR; regWrite, issue and clear SHALL be ignored in CLEAR.
REQ-025 Reads during CLEAR SHALL return current stored values (partially cleared contents visible).

Reset
REQ-026 When reset=0 at a rising edge: all registers 0, all busy bits 0, FSM IDLE, counter 0, clearBusy 0.
REQ-027 Reset SHALL take priority over write, issue and clear, including mid-CLEAR sequence.

Configuration
REQ-028 Macro REGFILE_BYPASS_EN SHALL, when defined, forward writeData to readDataN and force busyN=0 when a write is accepted this cycle to writeReg=readRegN (excluding hardwired register 0).
REQ-029 Without REGFILE_BYPASS_EN, readDataN and busyN SHALL reflect stored state only; a written value is visible the cycle after the write.

Verification
REQ-030 Reset low one edge, then read all addresses -> readData1/2 = 0, busy1/2 = 0, clearBusy = 0.
REQ-031 Write 0xBEEF to r3, then read r3 next cycle -> readData1 = 0xBEEF; write 0x1234 to r0 -> r0 reads 0.
REQ-032 issue r5, then read r5 -> busy1 = 1; write 0x00AA to r5 -> busy1 = 0 next cycle; issue+write r5 same edge -> busy1 = 1, data 0x00AA.
REQ-033 Fill r1..r7 with nonzero values, pulse clear -> clearBusy = 1 for 8 cycles, regWrite ignored meanwhile, all registers 0 afterwards.
REQ-034 Start clear, assert reset=0 at cycle 3 -> next cycle clearBusy = 0, all registers 0, FSM IDLE.
REQ-035 regWrite r2 = 0x5A5A with readReg1 = 2 same cycle -> readData1 = 0x5A5A that cycle with REGFILE_BYPASS_EN, old value without.
